mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port (IF stage) and data-memory port (MEM stage). It serialises accesses with a small FSM and returns read data with a one-cycle valid pulse. It also drives per-port stall signals, which the hazard logic uses to freeze the PC, IF/ID and the later pipeline registers.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MEM_LAT, 2, memory access cycles per transaction; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid when if_valid=1
- if_valid  out  1  one-cycle completion pulse, fetch port
- if_stall  out  1  fetch port waiting
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_valid
- dm_we  in  1  1=write, 0=read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data; valid when dm_valid=1 and the access was a read
- dm_valid  out  1  one-cycle completion pulse, data port
- dm_stall  out  1  data port waiting
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid on the last cycle of an access

## Operation
- FSM states:
  - IDLE: no access in progress.
  - BUSY: access in progress for granted port g (g ∈ {IF, DM}); a down-counter of width clog2(MEM_LAT+1) tracks the remaining cycles.
  - RESP: completion cycle.
- IDLE:
  - If any request is present, latch the grant g and the winning port's command, load the counter with MEM_LAT, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - mem_en=1 every cycle; mem_we/mem_addr/mem_wdata come from the latched command and stay stable.
  - Counter decrements each cycle.
  - On the cycle the counter equals 1, mem_rdata is captured into the granted port's rdata register (reads only; writes leave rdata unchanged). Next state is RESP.
- RESP:
  - The granted port's valid = 1. mem_en = 0.
  - The served port's req is ignored this cycle, because it still reflects the completed transaction.
  - If the other port requests, grant it and go directly to BUSY. Otherwise go to IDLE.
- Arbitration on a tie (both requesting in IDLE): DM wins, under fixed priority.
- Stall outputs: if_stall = if_req & ~if_valid; dm_stall = dm_req & ~dm_valid. Both are combinational from inputs and registered state.
- rdata registers hold their value until the next read completion on the same port.
- Requester contract: in the cycle after its valid pulse, a port either deasserts req or presents a new transaction. Changing the command while req=1 and valid=0 is illegal and produces undefined data.

## Timing
- Reset (sync): state=IDLE, counter=0, grant=IF, all outputs 0, including if_rdata and dm_rdata.
- Request seen in IDLE at cycle t:
  - mem_en=1 for cycles t+1..t+MEM_LAT.
  - valid=1 at cycle t+MEM_LAT+1.
  - Total latency is MEM_LAT+1 cycles.
- Back-to-back different ports: the second access's BUSY starts the cycle after RESP, so there is no IDLE bubble.
- Same port back-to-back: passes through IDLE, giving a one-cycle bubble.
- MEM_LAT=1: BUSY lasts one cycle and capture happens in that cycle.
- Reset asserted mid-BUSY:
  - Access is abandoned and no valid pulse is issued.
  - A partially issued write may or may not have committed; the requester must reissue.
- A request arriving during BUSY or RESP for the busy port is not possible under the contract. A request from the other port waits, with its stall=1.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant register (reset value IF) records the last port served.
  - On a tie, the port not served last wins, so the first tie after reset goes to DM.
  - The RESP→BUSY handover to the other port is unchanged.
- MEM_ARB_RR_EN undefined: fixed priority, DM over IF; the last-grant register is not built.

## Test plan
- Single read, MEM_LAT=2:
  - Stimulus: if_req=1, if_addr=0x40 at cycle 1; memory returns 0x8C020004.
  - Required response: mem_en cycles 2–3, if_valid=1 with if_rdata=0x8C020004 at cycle 4, if_stall=1 during cycles 1–3.
- Tie, fixed priority:
  - Stimulus: if_req and dm_req (read 0x100) asserted together.
  - Required response: DM served first (dm_valid at t+3), IF BUSY begins at t+4 with no IDLE gap, if_valid at t+6.
- Write:
  - Stimulus: dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF, MEM_LAT=3.
  - Required response: mem_we=1 with those values for 3 cycles, dm_valid at t+4, dm_rdata unchanged.
- Reset mid-BUSY:
  - Stimulus: assert reset on the second BUSY cycle.
  - Required response: next cycle all outputs 0, state IDLE, no valid pulse afterwards.
- MEM_ARB_RR_EN defined, both ports continuously requesting for 8 transactions:
  - Required response: grants alternate DM, IF, DM, IF, …; each port completes exactly 4.
- MEM_LAT=1:
  - Stimulus: two consecutive IF reads of 0x0 and 0x4.
  - Required response: valids at t+2 and t+5, giving a one-cycle IDLE bubble.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline ports, mem_port_arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (DM over IF).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be within 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  typedef enum logic {PORT_IF = 1'b0, PORT_DM = 1'b1} port_e;

  state_e            state_q, state_d;
  port_e             grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic              launch;
  port_e             launch_port;
  port_e             tie_winner;
  logic              busy;
  logic              resp;

`ifdef MEM_ARB_RR_EN
  port_e last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_IF;
    end else if (launch) begin
      last_q <= launch_port;
    end
  end

  assign tie_winner = (last_q == PORT_IF) ? PORT_DM : PORT_IF;
`else
  assign tie_winner = PORT_DM;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= PORT_IF;
      cnt_q       <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    launch      = 1'b0;
    launch_port = PORT_IF;

    case (state_q)
      S_IDLE: begin
        if (bus.dm_req && bus.if_req) begin
          launch      = 1'b1;
          launch_port = tie_winner;
        end else if (bus.dm_req) begin
          launch      = 1'b1;
          launch_port = PORT_DM;
        end else if (bus.if_req) begin
          launch      = 1'b1;
          launch_port = PORT_IF;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
          if (!cmd_we_q) begin
            if (grant_q == PORT_IF) begin
              if_rdata_d = bus.mem_rdata;
            end else begin
              dm_rdata_d = bus.mem_rdata;
            end
          end
        end
      end

      S_RESP: begin
        // The served port's req still shows the finished access, so only the other port may launch.
        state_d = S_IDLE;
        if (grant_q == PORT_IF && bus.dm_req) begin
          launch      = 1'b1;
          launch_port = PORT_DM;
        end else if (grant_q == PORT_DM && bus.if_req) begin
          launch      = 1'b1;
          launch_port = PORT_IF;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d = S_BUSY;
      grant_d = launch_port;
      cnt_d   = CNT_W'(MEM_LAT);
      if (launch_port == PORT_DM) begin
        cmd_we_d    = bus.dm_we;
        cmd_addr_d  = bus.dm_addr;
        cmd_wdata_d = bus.dm_wdata;
      end else begin
        cmd_we_d    = 1'b0;
        cmd_addr_d  = bus.if_addr;
        cmd_wdata_d = '0;
      end
    end
  end

  assign busy = (state_q == S_BUSY);
  assign resp = (state_q == S_RESP);

  assign bus.mem_en    = busy;
  assign bus.mem_we    = busy & cmd_we_q;
  assign bus.mem_addr  = busy ? cmd_addr_q  : '0;
  assign bus.mem_wdata = busy ? cmd_wdata_q : '0;

  assign bus.if_valid  = resp && (grant_q == PORT_IF);
  assign bus.dm_valid  = resp && (grant_q == PORT_DM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_stall  = bus.if_req & ~bus.if_valid;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_valid;

endmodule
